// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration bridge.
package fll_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StRel,
        StResp
    } state_e;

    // FLL macro register offsets (addr[3:2])
    localparam logic [1:0] FLL_STATUS = 2'd0;
    localparam logic [1:0] FLL_CFG1   = 2'd1;
    localparam logic [1:0] FLL_CFG2   = 2'd2;
    localparam logic [1:0] FLL_INTEG  = 2'd3;

    // Local status page offsets
    localparam logic [1:0] STAT_LOCK      = 2'd0;
    localparam logic [1:0] STAT_LOCK_LOST = 2'd1;

    // One extra channel code is reserved for the local status page.
    function automatic int unsigned ch_width(input int unsigned num_fll);
        return $clog2(num_fll + 1);
    endfunction

endpackage

// File: rtl/fll_cfg_sync.sv
// Multi-stage synchroniser for asynchronous FLL handshake and lock inputs.
module fll_cfg_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '{default: '0};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/fll_cfg_bridge.sv
// Register-bus to multi-channel FLL config bridge: 4-phase CFGREQ/CFGACK per channel,
// ACK timeout and a local lock-status page.
module fll_cfg_bridge
    import fll_cfg_pkg::*;
#(
    parameter int unsigned NUM_FLL     = 2,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      reg_valid_i,
    input  logic                      reg_write_i,
    input  logic [ADDR_W-1:0]         reg_addr_i,
    input  logic [DATA_W-1:0]         reg_wdata_i,
    output logic                      reg_ready_o,
    output logic [DATA_W-1:0]         reg_rdata_o,
    output logic                      reg_error_o,
    output logic [NUM_FLL-1:0]        cfg_req_o,
    input  logic [NUM_FLL-1:0]        cfg_ack_i,
    output logic [1:0]                cfg_addr_o,
    output logic [DATA_W-1:0]         cfg_wdata_o,
    output logic                      cfg_wen_no,
    input  logic [NUM_FLL*DATA_W-1:0] cfg_rdata_i,
    input  logic [NUM_FLL-1:0]        lock_i
);

    localparam int unsigned     CH_W     = ch_width(NUM_FLL);
    localparam int unsigned     TMO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [CH_W-1:0] LOCAL_CH = CH_W'(NUM_FLL);

    state_e              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic                write_q, write_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic [DATA_W-1:0]   resp_data_q, resp_data_d;
    logic                resp_err_q, resp_err_d;
    logic                reg_ready_q, reg_ready_d;
    logic [DATA_W-1:0]   reg_rdata_q, reg_rdata_d;
    logic                reg_error_q, reg_error_d;
    logic [NUM_FLL-1:0]  cfg_req_q, cfg_req_d;
    logic [1:0]          cfg_addr_q, cfg_addr_d;
    logic [DATA_W-1:0]   cfg_wdata_q, cfg_wdata_d;
    logic                cfg_wen_q, cfg_wen_d;
    logic [NUM_FLL-1:0]  lock_lost_q, lock_lost_d;
    logic [NUM_FLL-1:0]  lock_prev_q;
    logic [NUM_FLL-1:0]  lock_clr;
    logic [NUM_FLL-1:0]  ack_sync, lock_sync;
    logic [CH_W-1:0]     req_ch;
    logic [1:0]          req_reg;
    logic                ack_sel;
    logic [DATA_W-1:0]   rdata_sel;
    logic                unused_addr;

    fll_cfg_sync #(.STAGES(SYNC_STAGES), .WIDTH(NUM_FLL)) u_ack_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cfg_ack_i),
        .q_o   (ack_sync)
    );

    fll_cfg_sync #(.STAGES(SYNC_STAGES), .WIDTH(NUM_FLL)) u_lock_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (lock_i),
        .q_o   (lock_sync)
    );

    assign req_ch      = reg_addr_i[4 +: CH_W];
    assign req_reg     = reg_addr_i[3:2];
    assign unused_addr = ^{reg_addr_i[ADDR_W-1:4+CH_W], reg_addr_i[1:0]};

    // Channel muxes written as loops so ch_q may safely exceed the channel range.
    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = '0;
        for (int i = 0; i < NUM_FLL; i++) begin
            if (ch_q == CH_W'(i)) begin
                ack_sel   = ack_sync[i];
                rdata_sel = cfg_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        write_d     = write_q;
        tmo_d       = '0;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        reg_ready_d = 1'b0;
        reg_rdata_d = '0;
        reg_error_d = 1'b0;
        cfg_req_d   = cfg_req_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_wen_d   = cfg_wen_q;
        lock_clr    = '0;

        unique case (state_q)
            StIdle: begin
                if (reg_valid_i) begin
                    ch_d        = req_ch;
                    write_d     = reg_write_i;
                    resp_data_d = '0;
                    resp_err_d  = 1'b0;
                    if (req_ch < LOCAL_CH) begin
                        cfg_addr_d  = req_reg;
                        cfg_wdata_d = reg_wdata_i;
                        cfg_wen_d   = ~reg_write_i;
                        for (int i = 0; i < NUM_FLL; i++) begin
                            cfg_req_d[i] = (req_ch == CH_W'(i));
                        end
                        state_d = StReq;
                    end else if (req_ch == LOCAL_CH) begin
                        if (reg_write_i) begin
                            if (req_reg == STAT_LOCK_LOST) begin
                                lock_clr = reg_wdata_i[NUM_FLL-1:0];
                            end
                        end else begin
                            case (req_reg)
                                STAT_LOCK:      resp_data_d = DATA_W'(lock_sync);
                                STAT_LOCK_LOST: resp_data_d = DATA_W'(lock_lost_q);
                                default:        resp_data_d = '0;
                            endcase
                        end
                        state_d = StResp;
                    end else begin
                        resp_err_d = 1'b1;
                        state_d    = StResp;
                    end
                end
            end
            StReq: begin
                if (ack_sel) begin
                    if (!write_q) begin
                        resp_data_d = rdata_sel;
                    end
                    cfg_req_d = '0;
                    state_d   = StRel;
                end else if (tmo_q == TMO_LAST) begin
                    cfg_req_d  = '0;
                    resp_err_d = 1'b1;
                    state_d    = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StRel: begin
                if (!ack_sel) begin
                    state_d = StResp;
                end else if (tmo_q == TMO_LAST) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    state_d     = StResp;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StResp: begin
                reg_ready_d = 1'b1;
                reg_rdata_d = resp_data_q;
                reg_error_d = resp_err_q;
                state_d     = StIdle;
            end
        endcase

        // A fresh lock drop wins over a simultaneous write-1-clear.
        lock_lost_d = (lock_lost_q & ~lock_clr) | (lock_prev_q & ~lock_sync);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            write_q     <= 1'b0;
            tmo_q       <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            reg_ready_q <= 1'b0;
            reg_rdata_q <= '0;
            reg_error_q <= 1'b0;
            cfg_req_q   <= '0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            cfg_wen_q   <= 1'b1;
            lock_lost_q <= '0;
            lock_prev_q <= '0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            write_q     <= write_d;
            tmo_q       <= tmo_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
            reg_ready_q <= reg_ready_d;
            reg_rdata_q <= reg_rdata_d;
            reg_error_q <= reg_error_d;
            cfg_req_q   <= cfg_req_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_wen_q   <= cfg_wen_d;
            lock_lost_q <= lock_lost_d;
            lock_prev_q <= lock_sync;
        end
    end

    assign reg_ready_o = reg_ready_q;
    assign reg_rdata_o = reg_rdata_q;
    assign reg_error_o = reg_error_q;
    assign cfg_req_o   = cfg_req_q;
    assign cfg_addr_o  = cfg_addr_q;
    assign cfg_wdata_o = cfg_wdata_q;
    assign cfg_wen_no  = cfg_wen_q;

endmodule
